// File: rtl/multicycle_ctrl_if.sv
// Datapath <-> controller bundle for the multi-cycle RV32I core.
// master: the controller (drives selects/enables); slave: the datapath side.
interface multicycle_ctrl_if;
  // Instruction fields and status from the datapath
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  // Datapath controls
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [2:0] imm_src;
  logic [1:0] result_src;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    output alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, illegal, state
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    input  alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback
// over a shared memory, single ALU and register file, stalling on mem_ready.
module multicycle_ctrl (
  input logic                 clk,
  input logic                 rst,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StLui      = 4'd11,
    StTrap     = 4'd12
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  // Raw (pre-reset-gating) controls
  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;
  logic [2:0] alu_ctrl_c;

  // funct3 decodes shared by EXECR/EXECI/BRANCH
  logic [2:0] alu_r, alu_i;
  logic       alu_f3_ok;
  logic       br_f3_ok, br_take;

  // State and sticky illegal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Immediate format follows op in every state
  always_comb begin
    bus.imm_src = 3'b000;
    case (bus.op)
      OpStore:  bus.imm_src = 3'b001;
      OpBranch: bus.imm_src = 3'b010;
      OpJal:    bus.imm_src = 3'b011;
      OpLui:    bus.imm_src = 3'b100;
      default:  bus.imm_src = 3'b000;
    endcase
  end

  // ALU operation and branch condition from funct3
  always_comb begin
    alu_r     = AluAdd;
    alu_i     = AluAdd;
    alu_f3_ok = 1'b1;
    case (bus.funct3)
      3'b000: begin
        alu_r = bus.funct7b5 ? AluSub : AluAdd;
        alu_i = AluAdd;
      end
      3'b010: begin
        alu_r = AluSlt;
        alu_i = AluSlt;
      end
      3'b110: begin
        alu_r = AluOr;
        alu_i = AluOr;
      end
      3'b111: begin
        alu_r = AluAnd;
        alu_i = AluAnd;
      end
      default: alu_f3_ok = 1'b0;
    endcase
    br_f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
    // beq takes on zero, bne on non-zero
    br_take  = bus.funct3[0] ? ~bus.zero : bus.zero;
  end

  // Next-state and per-state controls
  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_ctrl_c   = AluAdd;
    result_src_c = 2'b00;

    case (state_q)
      StFetch: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        // Branch target OldPC + imm lands in ALUOut for BRANCH/JAL
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpLui:           state_d = StLui;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        // op[5] separates sw from lw
        state_d     = bus.op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (bus.mem_ready) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b00;
        alu_ctrl_c  = alu_r;
        state_d     = alu_f3_ok ? StAluWb : StTrap;
      end
      StExecI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_ctrl_c  = alu_i;
        state_d     = alu_f3_ok ? StAluWb : StTrap;
      end
      StAluWb: begin
        result_src_c = 2'b00;
        reg_write_c  = 1'b1;
        state_d      = StFetch;
      end
      StBranch: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b00;
        alu_ctrl_c  = AluSub;
        if (br_f3_ok) begin
          pc_write_c = br_take;
          state_d    = StFetch;
        end else begin
          state_d    = StTrap;
        end
      end
      StJal: begin
        // PC <- ALUOut (target); ALU computes OldPC + 4 for rd
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
        state_d     = StAluWb;
      end
      StLui: begin
        alu_src_a_c = 2'b11;
        alu_src_b_c = 2'b01;
        state_d     = StAluWb;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase

    illegal_d = illegal_q | (state_d == StTrap);
  end

  // Outputs; strobes are suppressed combinationally while reset is held
  always_comb begin
    bus.mem_req    = mem_req_c & rst;
    bus.mem_write  = mem_write_c & rst;
    bus.ir_write   = ir_write_c & rst;
    bus.pc_write   = pc_write_c & rst;
    bus.reg_write  = reg_write_c & rst;
    bus.adr_src    = adr_src_c;
    bus.alu_src_a  = alu_src_a_c;
    bus.alu_src_b  = alu_src_b_c;
    bus.alu_ctrl   = alu_ctrl_c;
    bus.result_src = result_src_c;
    bus.illegal    = illegal_q;
    bus.state      = state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each driven cycle pushes its expected state and
// control word; a monitor pops and compares one cycle record per clock.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  multicycle_ctrl_if bus_if ();

  multicycle_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Scoreboard: expected state, expected control word, tag
  logic [3:0]  exp_st_q[$];
  logic [18:0] exp_ctl_q[$];
  string       tag_q[$];

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic [2:0] cur_imm;

  logic [3:0]  mon_st;
  logic [18:0] mon_ctl;
  string       mon_tag;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] obs_ctl();
    return {bus_if.mem_req, bus_if.mem_write, bus_if.adr_src, bus_if.ir_write,
            bus_if.pc_write, bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b,
            bus_if.alu_ctrl, bus_if.imm_src, bus_if.result_src, bus_if.illegal};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  // Monitor: compare each cycle's outputs against the oldest expected record
  always @(negedge clk) begin
    #1;
    if (exp_st_q.size() != 0) begin
      mon_st  = exp_st_q.pop_front();
      mon_ctl = exp_ctl_q.pop_front();
      mon_tag = tag_q.pop_front();
      check_eq({mon_tag, ".state"}, 32'(bus_if.state), 32'(mon_st));
      check_eq({mon_tag, ".ctl"}, 32'(obs_ctl()), 32'(mon_ctl));
    end
  end

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [2:0] imm);
    cur_op  = op;
    cur_f3  = f3;
    cur_f7  = f7;
    cur_imm = imm;
  endtask

  // en = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
  task automatic step(input string tag, input logic mr, input logic z, input logic [3:0] st,
                      input logic [5:0] en, input logic [1:0] a, input logic [1:0] b,
                      input logic [2:0] alu, input logic [1:0] rs, input logic ill);
    @(negedge clk);
    rst              = 1'b1;
    bus_if.op        = cur_op;
    bus_if.funct3    = cur_f3;
    bus_if.funct7b5  = cur_f7;
    bus_if.zero      = z;
    bus_if.mem_ready = mr;
    exp_st_q.push_back(st);
    exp_ctl_q.push_back({en, a, b, alu, cur_imm, rs, ill});
    tag_q.push_back(tag);
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++)
      step("fetch_wait", 1'b0, rb(), 4'd0, 6'b100000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0);
    step("fetch", 1'b1, rb(), 4'd0, 6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0);
  endtask

  task automatic decode();
    step("decode", rb(), rb(), 4'd1, 6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic aluwb();
    step("aluwb", rb(), rb(), 4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic instr_i(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    set_instr(7'b0010011, f3, f7, 3'b000);
    fetch(0);
    decode();
    step("execi", rb(), rb(), 4'd7, 6'b000000, 2'b10, 2'b01, alu, 2'b00, 1'b0);
    aluwb();
  endtask

  task automatic instr_r(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    set_instr(7'b0110011, f3, f7, 3'b000);
    fetch(0);
    decode();
    step("execr", rb(), rb(), 4'd6, 6'b000000, 2'b10, 2'b00, alu, 2'b00, 1'b0);
    aluwb();
  endtask

  task automatic memadr();
    step("memadr", rb(), rb(), 4'd2, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic instr_lw(input int waits);
    set_instr(7'b0000011, 3'b010, 1'b0, 3'b000);
    fetch(0);
    decode();
    memadr();
    for (int i = 0; i < waits; i++)
      step("memread_wait", 1'b0, rb(), 4'd3, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    step("memread", 1'b1, rb(), 4'd3, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    step("memwb", rb(), rb(), 4'd4, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0);
  endtask

  task automatic instr_sw(input int waits);
    set_instr(7'b0100011, 3'b010, 1'b0, 3'b001);
    fetch(0);
    decode();
    memadr();
    for (int i = 0; i < waits; i++)
      step("memwrite_wait", 1'b0, rb(), 4'd5, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    step("memwrite", 1'b1, rb(), 4'd5, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic instr_br(input logic [2:0] f3, input logic z, input logic take);
    set_instr(7'b1100011, f3, 1'b0, 3'b010);
    fetch(0);
    decode();
    step("branch", rb(), z, 4'd9, take ? 6'b000010 : 6'b000000, 2'b10, 2'b00, 3'b001,
         2'b00, 1'b0);
  endtask

  task automatic instr_jal();
    set_instr(7'b1101111, 3'b000, 1'b0, 3'b011);
    fetch(0);
    decode();
    step("jal", rb(), rb(), 4'd10, 6'b000010, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0);
    aluwb();
  endtask

  task automatic instr_lui(input int fetch_waits);
    set_instr(7'b0110111, 3'b000, 1'b0, 3'b100);
    fetch(fetch_waits);
    decode();
    step("lui", rb(), rb(), 4'd11, 6'b000000, 2'b11, 2'b01, 3'b000, 2'b00, 1'b0);
    aluwb();
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++)
      step("trap", rb(), rb(), 4'd12, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1);
  endtask

  // Hold reset for a cycle with mem_ready high; strobes must stay low
  task automatic reset_check(input string tag);
    @(negedge clk);
    rst              = 1'b0;
    bus_if.mem_ready = 1'b1;
    #1;
    check_eq({tag, ".state"}, 32'(bus_if.state), 32'd0);
    check_eq({tag, ".illegal"}, 32'(bus_if.illegal), 32'd0);
    check_eq({tag, ".strobes"}, 32'({bus_if.mem_req, bus_if.mem_write, bus_if.ir_write,
                                      bus_if.pc_write, bus_if.reg_write}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus_if.op        = 7'd0;
    bus_if.funct3    = 3'd0;
    bus_if.funct7b5  = 1'b0;
    bus_if.zero      = 1'b0;
    bus_if.mem_ready = 1'b0;
    set_instr(7'd0, 3'd0, 1'b0, 3'd0);

    reset_check("por");

    // addi x1,x0,5 / add x2,x1,x1 / sw x2,0(x0)
    instr_i(3'b000, 1'b0, 3'b000);
    instr_r(3'b000, 1'b0, 3'b000);
    instr_sw(0);

    // ALU operation decode
    instr_r(3'b000, 1'b1, 3'b001);
    instr_i(3'b000, 1'b1, 3'b000);
    instr_r(3'b010, 1'b0, 3'b101);
    instr_r(3'b110, 1'b0, 3'b011);
    instr_r(3'b111, 1'b0, 3'b010);
    instr_i(3'b010, 1'b0, 3'b101);
    instr_i(3'b110, 1'b0, 3'b011);
    instr_i(3'b111, 1'b0, 3'b010);

    // Memory stalls
    instr_lw(3);
    instr_lw(0);
    instr_sw(2);

    // Branch decisions
    instr_br(3'b000, 1'b1, 1'b1);
    instr_br(3'b000, 1'b0, 1'b0);
    instr_br(3'b001, 1'b1, 1'b0);
    instr_br(3'b001, 1'b0, 1'b1);

    instr_jal();
    instr_lui(2);

    // Asynchronous reset in the middle of a stalled store
    set_instr(7'b0100011, 3'b010, 1'b0, 3'b001);
    fetch(0);
    decode();
    memadr();
    step("memwrite_wait", 1'b0, 1'b0, 4'd5, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check_eq("midrst.state", 32'(bus_if.state), 32'd0);
    check_eq("midrst.mem_write", 32'(bus_if.mem_write), 32'd0);
    check_eq("midrst.mem_req", 32'(bus_if.mem_req), 32'd0);
    instr_i(3'b110, 1'b0, 3'b011);

    // Unsupported funct3 in EXECR traps
    set_instr(7'b0110011, 3'b001, 1'b0, 3'b000);
    fetch(0);
    decode();
    step("execr_bad", rb(), rb(), 4'd6, 6'b000000, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0);
    trap_cycles(3);
    reset_check("rst_after_f3trap");

    // Unsupported opcode traps and stays trapped
    set_instr(7'b0001111, 3'b000, 1'b0, 3'b000);
    fetch(0);
    decode();
    trap_cycles(5);
    reset_check("rst_after_optrap");

    instr_lui(0);

    #5;
    check_eq("sb_drain", 32'(exp_st_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Finite-state controller that sequences a multi-cycle RV32I datapath. The datapath has one shared instruction/data memory, one ALU and one register file. Each instruction is split into fetch, decode, execute, memory and writeback steps. The block drives every mux select and write enable of the datapath and stalls on a ready handshake from the memory. It replaces the combinational decoder when the core moves from single-cycle to multi-cycle.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  7  instr[6:0], taken from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU result == 0; drives the branch decision.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  store when high, load/fetch when low.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and OldPC.
- pc_write  out  1  load the PC from the result bus.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  ALU A input: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B input: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- result_src  out  2  result bus: 00 = ALUOut, 01 = read data, 10 = ALU result.
- illegal  out  1  sticky flag: an unsupported instruction was decoded.
- state  out  4  current state encoding, for debug.

## Operation
- Supported instructions: lw, sw, R-type (add, sub, slt, or, and), I-type ALU (addi, slti, ori, andi), beq, bne, jal, lui.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, TRAP=12.
- Outputs are Moore outputs, except the mem_ready-qualified strobes and the branch pc_write. Unlisted enables are 0. Unlisted selects are 00 and alu_ctrl is add.
- imm_src is decoded from op in every state. An unsupported op gives 000.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
  - When mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE.
  - Otherwise stay in FETCH with both strobes at 0.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut). Dispatch on op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 0110111 -> LUI.
  - Any other op -> TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, add. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB, otherwise hold.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. On mem_ready go to FETCH, otherwise hold.
- EXECR: alu_src_a=10, alu_src_b=00, then go to ALUWB. alu_ctrl from funct3:
  - 000 gives sub when funct7b5=1, add otherwise.
  - 010 gives slt, 110 gives or, 111 gives and.
- EXECI: alu_src_a=10, alu_src_b=01, then go to ALUWB. alu_ctrl from funct3 as in EXECR, except funct7b5 is ignored (000 is always add).
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00, then go to FETCH.
  - funct3=000 (beq): pc_write = zero.
  - funct3=001 (bne): pc_write = ~zero.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 (target already in ALUOut), then go to ALUWB (rd = OldPC+4).
- LUI: alu_src_a=11, alu_src_b=01, add, then go to ALUWB.
- An unsupported funct3 in EXECR, EXECI or BRANCH sends the FSM to TRAP instead of its normal successor. All enables stay 0 in that cycle.
- TRAP: all enables 0, mem_req=0, illegal=1. TRAP is absorbing until reset.

## Timing
- Reset: state=FETCH, illegal=0. While rst is low, mem_req, mem_write, ir_write, pc_write and reg_write are forced to 0.
- First fetch request is in the first cycle after rst rises.
- Zero-wait latency per instruction:
  - lw 5 cycles, sw 4 cycles.
  - R-type, I-type, jal and lui 4 cycles each.
  - beq/bne 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. mem_req and adr_src hold stable throughout the wait.
- mem_ready is ignored in all states with mem_req=0.
- No write enable is asserted in two consecutive cycles for one instruction, except pc_write in JAL followed by reg_write in ALUWB.
- Reset asserted mid-instruction: the FSM returns to FETCH asynchronously. The in-flight memory request is dropped, and no partial register or PC write occurs after the reset edge.

## Test plan
- Reset, then program addi x1,x0,5 / add x2,x1,x1 / sw x2,0(x0) with mem_ready tied to 1:
  - state sequence 0,1,7,8 / 0,1,6,8 / 0,1,2,5.
  - reg_write pulses in cycles 4 and 8; mem_write in cycle 12.
- lw with mem_ready low for 3 cycles in MEMREAD: mem_req=1 and adr_src=1 are held for 4 cycles; lw completes in 8 cycles total.
- beq with zero=1 gives a pc_write pulse in BRANCH. beq with zero=0 gives no pc_write. bne gives the inverse of both.
- jal: pc_write in state 10, then reg_write with result_src=00 in state 8. sub (funct7b5=1) gives alu_ctrl=001 in EXECR. addi with instr[30]=1 still gives alu_ctrl=000.
- Illegal op 0001111 gives state=12 after DECODE: illegal=1 and every enable at 0 indefinitely. Reset then gives illegal=0 and state=0.
- rst asserted low during MEMWRITE while mem_ready=0: mem_write=0 immediately, state=0, and FETCH resumes one cycle after release.
